// File: rtl/jt51_logsin_if.sv
// Sample bus for the log-sine stage: phase/attenuation/tag in, attenuated
// log-sine magnitude with sign and tag out.
interface jt51_logsin_if #(
  parameter int AW   = 8,
  parameter int ATTW = 10,
  parameter int OW   = 13,
  parameter int TAGW = 5
);
  logic [AW+1:0]   phase;
  logic [ATTW-1:0] atten;
  logic [TAGW-1:0] tag_in;
  logic            vld_in;
  logic [OW-1:0]   logsin;
  logic            sign;
  logic [TAGW-1:0] tag_out;
  logic            vld_out;

  modport master (
    output phase, atten, tag_in, vld_in,
    input  logsin, sign, tag_out, vld_out
  );

  modport slave (
    input  phase, atten, tag_in, vld_in,
    output logsin, sign, tag_out, vld_out
  );
endinterface

// File: rtl/jt51_logsin.sv
// Three-stage log-sine lookup: fold the phase into a quarter wave, read the
// -log2(sin) table, add attenuation and saturate to the output width.
module jt51_logsin #(
  parameter int AW   = 8,
  parameter int DW   = 12,
  parameter int ATTW = 10,
  parameter int OW   = 13,
  parameter int TAGW = 5
) (
  input  logic             rst,
  input  logic             clk,
  input  logic             cen,
  jt51_logsin_if.slave     bus
);

  localparam int SW = ((DW > ATTW + 2) ? DW : ATTW + 2) + 1;
  localparam int XW = (SW > OW) ? SW : OW;

  function automatic logic [DW-1:0] tbl_entry(input int i);
    real x;
    real v;
    int  r;
    x = (real'(i) + 0.5) / real'(2**AW) * 1.5707963267948966;
    v = -($ln($sin(x)) / $ln(2.0)) * 256.0;
    r = $rtoi(v + 0.5);
    if (r > 2**DW - 1) r = 2**DW - 1;
    tbl_entry = DW'(r);
  endfunction

  function automatic logic [OW-1:0] sat(input logic [SW-1:0] s);
    logic [XW-1:0] e;
    e = XW'(s);
    if (e > XW'({OW{1'b1}})) sat = '1;
    else                     sat = e[OW-1:0];
  endfunction

  // Table entries are elaboration-time constants; the lookup register makes it a sync ROM.
  logic [DW-1:0] rom_tbl [2**AW];

  for (genvar gi = 0; gi < 2**AW; gi++) begin : g_tbl
    localparam logic [DW-1:0] ENT = tbl_entry(gi);
    assign rom_tbl[gi] = ENT;
  end

  logic [AW-1:0]   addr_p0;
  logic            sign_p0;
  logic [ATTW-1:0] atten_p0;
  logic [TAGW-1:0] tag_p0;
  logic            vld_p0;

  logic [DW-1:0]   rom_p1;
  logic            sign_p1;
  logic [ATTW-1:0] atten_p1;
  logic [TAGW-1:0] tag_p1;
  logic            vld_p1;
  logic [SW-1:0]   sum_p1;

  logic [OW-1:0]   logsin_p2;
  logic            sign_p2;
  logic [TAGW-1:0] tag_p2;
  logic            vld_p2;

  assign sum_p1 = SW'(rom_p1) + (SW'(atten_p1) << 2);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_p0   <= '0;
      sign_p0   <= 1'b0;
      atten_p0  <= '0;
      tag_p0    <= '0;
      vld_p0    <= 1'b0;
      rom_p1    <= '0;
      sign_p1   <= 1'b0;
      atten_p1  <= '0;
      tag_p1    <= '0;
      vld_p1    <= 1'b0;
      logsin_p2 <= '0;
      sign_p2   <= 1'b0;
      tag_p2    <= '0;
      vld_p2    <= 1'b0;
    end else if (cen) begin
      // Stage p0: fold the second quarter of each half-wave back onto the first.
      addr_p0   <= bus.phase[AW-1:0] ^ {AW{bus.phase[AW]}};
      sign_p0   <= bus.phase[AW+1];
      atten_p0  <= bus.atten;
      tag_p0    <= bus.tag_in;
      vld_p0    <= bus.vld_in;
      // Stage p1: table lookup.
      rom_p1    <= rom_tbl[addr_p0];
      sign_p1   <= sign_p0;
      atten_p1  <= atten_p0;
      tag_p1    <= tag_p0;
      vld_p1    <= vld_p0;
      // Stage p2: attenuate and clamp.
      logsin_p2 <= sat(sum_p1);
      sign_p2   <= sign_p1;
      tag_p2    <= tag_p1;
      vld_p2    <= vld_p1;
    end
  end

  assign bus.logsin  = logsin_p2;
  assign bus.sign    = sign_p2;
  assign bus.tag_out = tag_p2;
  assign bus.vld_out = vld_p2;

endmodule

// File: tb/tb_jt51_logsin.sv
// Bench for jt51_logsin: three instances (default, OW=12, AW=10) driven with
// the same samples and compared against a table-based reference.
module tb_jt51_logsin;

  logic clk = 1'b0;
  logic rst;
  logic cen;

  always #5 clk = ~clk;

  jt51_logsin_if #(.AW(8),  .ATTW(10), .OW(13), .TAGW(5)) ifa ();
  jt51_logsin_if #(.AW(8),  .ATTW(10), .OW(12), .TAGW(5)) ifs ();
  jt51_logsin_if #(.AW(10), .ATTW(10), .OW(13), .TAGW(5)) ifw ();

  jt51_logsin #(.AW(8),  .DW(12), .ATTW(10), .OW(13), .TAGW(5)) dut_a (
    .rst(rst), .clk(clk), .cen(cen), .bus(ifa));
  jt51_logsin #(.AW(8),  .DW(12), .ATTW(10), .OW(12), .TAGW(5)) dut_s (
    .rst(rst), .clk(clk), .cen(cen), .bus(ifs));
  jt51_logsin #(.AW(10), .DW(12), .ATTW(10), .OW(13), .TAGW(5)) dut_w (
    .rst(rst), .clk(clk), .cen(cen), .bus(ifw));

  int n_vec;
  int n_err;
  int tbl8  [256];
  int tbl10 [1024];

  int cur_ph, cur_at, cur_tg, cur_vld;
  int h_ph [8];
  int h_at [8];
  int h_tg [8];
  int h_vld[8];
  int cnt;

  function automatic int ref_entry(input int aw, input int i);
    real x;
    real v;
    int  r;
    x = (real'(i) + 0.5) / (2.0 ** aw) * (3.14159265358979323846 / 2.0);
    v = -($ln($sin(x)) / $ln(2.0)) * 256.0;
    r = $rtoi(v + 0.5);
    if (r > 4095) r = 4095;
    return r;
  endfunction

  // Magnitude from first principles: mirror the offset in odd quarters, add 4*atten, clamp.
  function automatic int ref_mag(input int aw, input int ow, input int ph, input int at);
    int q, off, idx, e, s, mx;
    q   = 1 << aw;
    off = ph % q;
    idx = (((ph / q) % 2) == 1) ? (q - 1 - off) : off;
    e   = (aw == 8) ? tbl8[idx] : tbl10[idx];
    s   = e + 4 * at;
    mx  = (1 << ow) - 1;
    return (s > mx) ? mx : s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int ph, input int at, input int tg, input int v);
    cur_ph = ph; cur_at = at; cur_tg = tg; cur_vld = v;
    ifa.phase = 10'(ph); ifs.phase = 10'(ph); ifw.phase = 12'(ph);
    ifa.atten = 10'(at); ifs.atten = 10'(at); ifw.atten = 10'(at);
    ifa.tag_in = 5'(tg); ifs.tag_in = 5'(tg); ifw.tag_in = 5'(tg);
    ifa.vld_in = 1'(v);  ifs.vld_in = 1'(v);  ifw.vld_in = 1'(v);
  endtask

  task automatic rst_checks(input string tag);
    chk({tag, "_mag_a"}, ifa.logsin, 0);  chk({tag, "_vld_a"}, ifa.vld_out, 0);
    chk({tag, "_sgn_a"}, ifa.sign, 0);    chk({tag, "_tag_a"}, ifa.tag_out, 0);
    chk({tag, "_mag_s"}, ifs.logsin, 0);  chk({tag, "_vld_s"}, ifs.vld_out, 0);
    chk({tag, "_sgn_s"}, ifs.sign, 0);    chk({tag, "_tag_s"}, ifs.tag_out, 0);
    chk({tag, "_mag_w"}, ifw.logsin, 0);  chk({tag, "_vld_w"}, ifw.vld_out, 0);
    chk({tag, "_sgn_w"}, ifw.sign, 0);    chk({tag, "_tag_w"}, ifw.tag_out, 0);
  endtask

  task automatic check_all();
    int m, r, ph;
    m = cnt - 2;
    if (m < 1) begin
      chk("vld_a_idle", ifa.vld_out, 0);
      chk("vld_s_idle", ifs.vld_out, 0);
      chk("vld_w_idle", ifw.vld_out, 0);
    end else begin
      r = m % 8;
      ph = h_ph[r];
      if (h_vld[r] != 0) begin
        chk("vld_a", ifa.vld_out, 1);
        chk("mag_a", ifa.logsin, ref_mag(8, 13, ph % 1024, h_at[r]));
        chk("sgn_a", ifa.sign, (ph / 512) % 2);
        chk("tag_a", ifa.tag_out, h_tg[r]);
        chk("vld_s", ifs.vld_out, 1);
        chk("mag_s", ifs.logsin, ref_mag(8, 12, ph % 1024, h_at[r]));
        chk("sgn_s", ifs.sign, (ph / 512) % 2);
        chk("tag_s", ifs.tag_out, h_tg[r]);
        chk("vld_w", ifw.vld_out, 1);
        chk("mag_w", ifw.logsin, ref_mag(10, 13, ph, h_at[r]));
        chk("sgn_w", ifw.sign, (ph / 2048) % 2);
        chk("tag_w", ifw.tag_out, h_tg[r]);
      end else begin
        chk("vld_a_bub", ifa.vld_out, 0);
        chk("vld_s_bub", ifs.vld_out, 0);
        chk("vld_w_bub", ifw.vld_out, 0);
      end
    end
  endtask

  task automatic step(input logic c);
    int r;
    cen = c;
    @(posedge clk);
    #1;
    if (c) begin
      cnt++;
      r = cnt % 8;
      h_ph[r] = cur_ph; h_at[r] = cur_at; h_tg[r] = cur_tg; h_vld[r] = cur_vld;
    end
    check_all();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int d_ph   [8];
    int d_at   [8];
    int d_ea   [8];
    int d_es   [8];
    int d_sg   [8];
    int ph;

    n_vec = 0; n_err = 0; cnt = 0;
    rst = 1'b0; cen = 1'b0;
    drive(0, 0, 0, 0);
    for (int i = 0; i < 256; i++)  tbl8[i]  = ref_entry(8, i);
    for (int i = 0; i < 1024; i++) tbl10[i] = ref_entry(10, i);

    // Reset held across edges with cen low, then with cen high and valid input.
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_checks("rst_cen0");
    cen = 1'b1;
    drive(5, 7, 9, 1);
    repeat (2) @(posedge clk);
    #1 rst_checks("rst_cen1");
    rst = 1'b0; cnt = 0;
    drive(0, 0, 0, 0);

    // Directed samples with known magnitudes.
    d_ph[0] = 'h000; d_at[0] = 'h000; d_ea[0] = 'h859;  d_es[0] = 'h859; d_sg[0] = 0;
    d_ph[1] = 'h0FF; d_at[1] = 'h000; d_ea[1] = 'h000;  d_es[1] = 'h000; d_sg[1] = 0;
    d_ph[2] = 'h100; d_at[2] = 'h000; d_ea[2] = 'h000;  d_es[2] = 'h000; d_sg[2] = 0;
    d_ph[3] = 'h1FF; d_at[3] = 'h000; d_ea[3] = 'h859;  d_es[3] = 'h859; d_sg[3] = 0;
    d_ph[4] = 'h2FF; d_at[4] = 'h000; d_ea[4] = 'h000;  d_es[4] = 'h000; d_sg[4] = 1;
    d_ph[5] = 'h380; d_at[5] = 'h000; d_ea[5] = tbl8[127]; d_es[5] = tbl8[127]; d_sg[5] = 1;
    d_ph[6] = 'h000; d_at[6] = 'h3FF; d_ea[6] = 'h1855; d_es[6] = 'hFFF; d_sg[6] = 0;
    d_ph[7] = 'h080; d_at[7] = 'h000; d_ea[7] = 'h07F;  d_es[7] = 'h07F; d_sg[7] = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(d_ph[i], d_at[i], i + 3, 1);
      else       drive(0, 0, 0, 0);
      step(1'b1);
      if (i >= 2) begin
        chk("dir_mag_a", ifa.logsin, d_ea[i-2]);
        chk("dir_mag_s", ifs.logsin, d_es[i-2]);
        chk("dir_sgn_a", ifa.sign, d_sg[i-2]);
        chk("dir_tag_a", ifa.tag_out, i + 1);
        chk("dir_vld_a", ifa.vld_out, 1);
      end
    end

    // Clock-enable gating on a phase ramp: pattern 1,0,0,1,...
    ph = 'h3F0;
    for (int i = 0; i < 48; i++) begin
      drive(ph, $urandom_range(0, 1023), $urandom_range(0, 31), 1);
      step(((i % 4) == 0 || (i % 4) == 3) ? 1'b1 : 1'b0);
      if ((i % 4) == 0 || (i % 4) == 3) ph = (ph + 1) % 4096;
    end

    // Asynchronous reset while three valid samples are in flight.
    for (int k = 0; k < 3; k++) begin
      drive($urandom_range(0, 4095), $urandom_range(0, 1023), $urandom_range(0, 31), 1);
      step(1'b1);
    end
    #2 rst = 1'b1;
    #1 rst_checks("rst_mid");
    #1 rst = 1'b0;
    cnt = 0;
    drive(0, 0, 0, 0);
    repeat (4) step(1'b1);

    // Full phase sweep with random attenuation, tag and valid.
    for (int i = 0; i < 4096; i++) begin
      drive(i, $urandom_range(0, 1023), $urandom_range(0, 31),
            ($urandom_range(0, 3) != 0) ? 1 : 0);
      step(1'b1);
    end
    drive(0, 0, 0, 0);
    repeat (3) step(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/jt51_logsin.md
JT51_LOGSIN -- requirements
Module: jt51_logsin

Interface
REQ-001 Parameter AW, default 8: quarter-wave table address width; the table has 2^AW entries.
REQ-002 Parameter DW, default 12: table entry width.
REQ-003 Parameter ATTW, default 10: attenuation input width.
REQ-004 Parameter OW, default 13: output width; valid range DW-1 to DW+2.
REQ-005 Parameter TAGW, default 5: width of the operator/channel tag carried alongside each sample.
REQ-006 rst  in  1  reset; one clock; reset is asynchronous and active-high.
REQ-007 clk  in  1  system clock; all state updates on its rising edge.
REQ-008 cen  in  1  clock enable; pipeline advances only when high.
REQ-009 phase  in  AW+2  full-wave phase; MSB is half-wave, next bit is quarter-wave, low AW bits are the quarter offset.
REQ-010 atten  in  ATTW  log attenuation; each LSB weighs 4 table LSBs.
REQ-011 tag_in  in  TAGW  opaque tag for the sample.
REQ-012 vld_in  in  1  input sample valid.
REQ-013 logsin  out  OW  attenuated log-sine magnitude, saturated.
REQ-014 sign  out  1  output sign; 1 = negative half-wave.
REQ-015 tag_out  out  TAGW  tag aligned with logsin.
REQ-016 vld_out  out  1  output valid.

Function
REQ-017 Table entry i SHALL be round(-log2(sin((i+0.5)/2^AW * pi/2)) * 256), clipped to 2^DW-1; for AW=8, entry 0 = 0x859, entry 128 = 0x07F, entry 255 = 0x000.
REQ-018 The table SHALL be a synchronous ROM, computed at elaboration, not loaded from a file.
REQ-019 Stage 1 (fold): addr = phase[AW-1:0] XOR {AW{phase[AW]}}; sign1 = phase[AW+1]; atten, tag and valid registered alongside.
REQ-020 Stage 2 (lookup): rom = table[addr]; sign, atten, tag and valid delayed one stage.
REQ-021 Stage 3 (sum): sum = rom + (atten << 2), computed at max(DW, ATTW+2)+1 bits with no truncation.
REQ-022 If sum > 2^OW-1, logsin SHALL be 2^OW-1; otherwise logsin SHALL be sum.
REQ-023 Latency SHALL be exactly 3 cen-high cycles from the input sample to the matching output; throughput is one sample per cen-high cycle.
REQ-024 When cen is low, all pipeline registers and outputs SHALL hold their values, including vld_out.
REQ-025 Samples with vld_in=0 SHALL propagate as bubbles with vld_out=0; data outputs for bubbles are don't-care but SHALL be deterministic.
REQ-026 There is no backpressure; the consumer SHALL accept every vld_out=1 cycle when cen is high.
REQ-027 Phase wrap-around from 2^(AW+2)-1 to 0 SHALL need no special handling; folding is purely combinational on each sample.
REQ-028 sign SHALL follow phase[AW+1] even when the magnitude is saturated or the entry is 0.

Reset
REQ-029 While rst is high, all stage registers, logsin, sign, tag_out and vld_out SHALL be 0, regardless of clk and cen.
REQ-030 Asserting rst mid-stream SHALL discard all in-flight samples; none SHALL emerge after rst is released.
REQ-031 After rst is released, the first valid output SHALL appear 3 cen-high cycles after the first accepted vld_in=1.
REQ-032 The ROM contents SHALL be unaffected by reset.

Verification
REQ-033 Defaults; cen=1; phase=0x000, atten=0, vld_in=1, tag_in=3 -> 3 cycles later: logsin=0x859, sign=0, tag_out=3, vld_out=1.
REQ-034 Folding: phase 0x0FF -> 0x000; 0x100 -> 0x000; 0x1FF -> 0x859; 0x2FF -> 0x000 with sign=1; 0x380 -> table[0x7F] with sign=1.
REQ-035 Attenuation: phase 0x000, atten 0x3FF -> logsin=0x1855; with OW=12, the same stimulus -> logsin=0xFFF (saturated).
REQ-036 cen gating: cen toggling 1,0,0,1,... with a phase ramp -> outputs match the ungated golden model indexed by cen-high count; values hold during cen=0.
REQ-037 Reset mid-operation: rst pulsed high asynchronously between clk edges while 3 valid samples are in flight -> vld_out=0 immediately; no stale samples after release.
REQ-038 Sweep: all 1024 phases with random atten, tag and vld_in -> bit-exact against the REQ-017/REQ-022 model; also repeat with AW=10.
